// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM encodings,
// Booth digit op codes and the accumulator width set by cla_16.
package booth_mul_seq_pkg;

  localparam int ACC_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_PA   = 3'd1,
    OP_P2A  = 3'd2,
    OP_NA   = 3'd3,
    OP_N2A  = 3'd4
  } booth_op_e;

  // Radix-4 recode of an overlapping multiplier triplet {b(i+1), b(i), b(i-1)}.
  function automatic booth_op_e booth_recode(input logic [2:0] bits);
    booth_op_e op;
    case (bits)
      3'b001, 3'b010: op = OP_PA;
      3'b011:         op = OP_P2A;
      3'b100:         op = OP_N2A;
      3'b101, 3'b110: op = OP_NA;
      default:        op = OP_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_enc_r4.sv
// Radix-4 Booth digit encoder: turns the low multiplier triplet into
// sign and magnitude-select controls for the partial product.
module booth_enc_r4
  import booth_mul_seq_pkg::*;
(
  input  logic [2:0] mplier_bits,
  output logic       neg,
  output logic       one,
  output logic       two
);

  booth_op_e op;

  always_comb begin
    op  = booth_recode(mplier_bits);
    neg = (op == OP_NA) || (op == OP_N2A);
    one = (op == OP_PA) || (op == OP_NA);
    two = (op == OP_P2A) || (op == OP_N2A);
  end

endmodule

// File: rtl/cla_16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead
// carry network across the groups.
module cla_16 (
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = op_a & op_b;
  assign p = op_a ^ op_b;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  // Each bit carry is expanded from its group carry-in, never from a sibling bit.
  always_comb begin
    logic carry;
    carry = 1'b0;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        carry = gc[k];
        for (int m = 0; m < j; m++) begin
          carry = g[4*k+m] | (p[4*k+m] & carry);
        end
        c[4*k+j] = carry;
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative signed radix-4 Booth multiplier: one Booth digit per cycle,
// partial products accumulated through a single cla_16.
module booth_mul_seq
  import booth_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [1:0] CNT_LAST = 2'(WIDTH/2 - 1);

  logic [1:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               dig_neg, dig_one, dig_two;
  logic [ACC_W-1:0]   mult, pp, cla_b, cla_sum;
  logic               cla_cin, cla_cout_unused;

  booth_enc_r4 u_enc (
    .mplier_bits (mplier_q[2:0]),
    .neg         (dig_neg),
    .one         (dig_one),
    .two         (dig_two)
  );

  // Subtraction goes through the same adder as ~pp + 1; carry-out is dropped (mod 2^16).
  always_comb begin
    mult    = dig_two ? (mcand_q << 1) : (dig_one ? mcand_q : '0);
    pp      = mult << {cnt_q, 1'b0};
    cla_b   = dig_neg ? ~pp : pp;
    cla_cin = dig_neg;
  end

  cla_16 u_cla (
    .op_a (acc_q),
    .op_b (cla_b),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout_unused)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = {{(ACC_W-WIDTH){op_a[WIDTH-1]}}, op_a};
          mplier_d = {op_b, 1'b0};
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d    = cla_sum;
        mplier_d = {{2{mplier_q[WIDTH]}}, mplier_q[WIDTH:2]};
        if (cnt_q == CNT_LAST) begin
          // Product is loaded together with entering DONE so it is valid while done is high.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          product_d = cla_sum[2*WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq (WIDTH=8) with a product scoreboard.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_done = -1;
  bit          gap_chk = 1'b0;
  logic        done_prev = 1'b0;
  logic [15:0] exp_q[$];

  booth_mul_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard consumer and done-pulse shape checks.
  always @(negedge clk) begin
    if (done) begin
      chk("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
      if (gap_chk && last_done >= 0) chk("done_gap", cyc - last_done, 32'd6);
      last_done = cyc;
    end
    if (done && done_prev) chk("done_width", {31'd0, done}, 32'd0);
    done_prev = done;
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("idle_timeout", {31'd0, busy}, 32'd0);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n_done;
    logic [15:0] e;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;

    // 3*5 latency and busy profile; cycle 1 is the first after the accepting edge.
    exp_q.push_back(16'h000F);
    do_op(8'd3, 8'd5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      chk("lat_done", {31'd0, done}, {31'd0, k == 5});
    end
    @(negedge clk);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_done", {31'd0, done}, 32'd0);
    chk("hold_product", {16'd0, product}, 32'h000F);

    // Directed corner products.
    exp_q.push_back(16'h4000); do_op(8'h80, 8'h80);
    exp_q.push_back(16'hC080); do_op(8'h80, 8'h7F);
    exp_q.push_back(16'hFFEB); do_op(8'd7,  8'hFD);
    exp_q.push_back(16'h0000); do_op(8'd0,  8'hB3);
    wait_idle();

    // Back-to-back sweep: every multiplicand against 32 spread multipliers.
    last_done = -1;
    gap_chk   = 1'b1;
    for (int ia = -128; ia < 128; ia++) begin
      for (int j = 0; j < 32; j++) begin
        int ib;
        ib = -128 + j*8 + (j % 8);
        e  = 16'(ia * ib);
        exp_q.push_back(e);
        do_op(8'(ia), 8'(ib));
      end
    end
    wait_idle();
    gap_chk = 1'b0;

    // start during CALC with other operands must be ignored.
    exp_q.push_back(16'hFF9D);
    do_op(8'd9, 8'hF5);
    @(negedge clk);
    @(negedge clk);
    op_a  = 8'd50;
    op_b  = 8'd50;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("ign_done_cnt", n_done, 32'd1);
    chk("ign_product", {16'd0, product}, 32'h0000FF9D);
    chk("ign_busy", {31'd0, busy}, 32'd0);

    // start held high: a new operation every IDLE cycle.
    wait_idle();
    repeat (3) exp_q.push_back(16'hFFBF);
    last_done = -1;
    gap_chk   = 1'b1;
    @(negedge clk);
    op_a   = 8'hFB;
    op_b   = 8'd13;
    start  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40 && n_done < 3; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    chk("held_done_cnt", n_done, 32'd3);
    wait_idle();
    gap_chk = 1'b0;

    // Reset during CALC cycle 2 aborts without a done.
    do_op(8'd100, 8'd100);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 32'd0);
    exp_q.push_back(16'h002A);
    do_op(8'd6, 8'd7);
    wait_idle();
    chk("after_abort_product", {16'd0, product}, 32'h0000002A);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
